// File: rtl/mixed_block_c_packer_pkg.sv
// Shared block-C record types, collector state encoding and default-geometry header helpers.
// Header layout: item k at [k*ITEM_W +: ITEM_W], count field directly above the last item slot.
package mixed_block_c_packer_pkg;

    typedef logic [1:0] cSizeT;
    typedef logic [2:0] cSizePlusT;

    // variablec2 is declared first so the packed item reads {variablec2, variablec}
    typedef struct packed {
        cSizePlusT variablec2;
        cSizeT     variablec;
    } packerItemSt;

    localparam int DEF_ITEMS = 2;
    localparam int ITEM_W    = $bits(packerItemSt);
    localparam int CNT_W     = $clog2(DEF_ITEMS + 1);
    localparam int DEF_HDR_W = DEF_ITEMS * ITEM_W + CNT_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_FLUSH_PEND
    } collector_state_e;

    function automatic logic [DEF_HDR_W-1:0] pack_hdr(
        input packerItemSt [DEF_ITEMS-1:0] items,
        input logic [CNT_W-1:0]            count
    );
        logic [DEF_HDR_W-1:0] hdr;
        hdr = '0;
        for (int k = 0; k < DEF_ITEMS; k++) begin
            if (k < int'(count)) hdr[k*ITEM_W +: ITEM_W] = items[k];
        end
        hdr[DEF_ITEMS*ITEM_W +: CNT_W] = count;
        return hdr;
    endfunction

endpackage

// File: rtl/mixed_block_c_hdr_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with occupancy; head is registered, reads 0 when empty.
// Push is dropped when full and pop when empty; wrap-bit pointers distinguish full from empty.
module mixed_block_c_hdr_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_dat_i,
    input  logic                       pop_i,
    output logic                       rd_vld_o,
    output logic [WIDTH-1:0]           rd_dat_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic             empty, do_push, do_pop;

    assign empty   = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty;
    assign wr_d    = do_push ? wr_q + PW'(1) : wr_q;
    assign rd_d    = do_pop ? rd_q + PW'(1) : rd_q;

    assign rd_vld_o = !empty;
    assign rd_dat_o = empty ? '0 : mem_q[rd_q[AW-1:0]];
    assign level_o  = wr_q - rd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= push_dat_i;
    end

endmodule

// File: rtl/mixed_block_c_packer.sv
// Packs ITEMS {variablec2,variablec} records plus a count into one header; headers appear one cycle after push.
// in_ready drops while a flush is pending or the completing record would find the FIFO full; optional MIXED_BLOCK_C_PACKER_TIMEOUT_EN auto-flush.
module mixed_block_c_packer
    import mixed_block_c_packer_pkg::*;
#(
    parameter int C_WIDTH   = 2,
    parameter int CP_WIDTH  = 3,
    parameter int ITEMS     = 2,
    parameter int HDR_WIDTH = 13,
    parameter int DEPTH     = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [C_WIDTH-1:0]         in_variablec,
    input  logic [CP_WIDTH-1:0]        in_variablec2,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [HDR_WIDTH-1:0]       out_hdr,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       busy
);
    localparam int IW = C_WIDTH + CP_WIDTH;
    localparam int CW = $clog2(ITEMS + 1);

    if (ITEMS < 1) begin : g_bad_items
        $error("ITEMS must be >= 1");
    end
    if (HDR_WIDTH < ITEMS * IW + CW) begin : g_bad_hdr
        $error("HDR_WIDTH too narrow for ITEMS records plus count");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two >= 2");
    end

    collector_state_e           state_q, state_d;
    logic [CW-1:0]              count_q, count_d, cnt_n;
    logic [ITEMS-1:0][IW-1:0]   items_q, items_d, items_n;
    logic [HDR_WIDTH-1:0]       push_hdr;
    logic                       accept, push, flush_any, tmo_flush, fifo_full;

    assign in_ready  = (state_q != ST_FLUSH_PEND) && ((int'(count_q) < ITEMS - 1) || !fifo_full);
    assign accept    = in_valid && in_ready;
    assign flush_any = flush || tmo_flush;
    assign busy      = (count_q != '0) || (state_q == ST_FLUSH_PEND);

    // Contents after this cycle's accept; a flush in the same cycle includes the new record.
    always_comb begin
        items_n = items_q;
        cnt_n   = count_q + CW'(accept);
        for (int k = 0; k < ITEMS; k++) begin
            if (accept && count_q == CW'(k)) items_n[k] = {in_variablec2, in_variablec};
        end
        push_hdr = '0;
        for (int k = 0; k < ITEMS; k++) begin
            if (k < int'(cnt_n)) push_hdr[k*IW +: IW] = items_n[k];
        end
        push_hdr[ITEMS*IW +: CW] = cnt_n;
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        items_d = items_q;
        push    = 1'b0;
        if (state_q == ST_FLUSH_PEND) begin
            if (!fifo_full) begin
                push    = 1'b1;
                count_d = '0;
                state_d = ST_IDLE;
            end
        end else begin
            items_d = items_n;
            count_d = cnt_n;
            state_d = (cnt_n == '0) ? ST_IDLE : ST_FILL;
            if ((accept && int'(cnt_n) == ITEMS) || (flush_any && cnt_n != '0)) begin
                if (!fifo_full) begin
                    push    = 1'b1;
                    count_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FLUSH_PEND;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            items_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            items_q <= items_d;
        end
    end

`ifdef MIXED_BLOCK_C_PACKER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q, tmo_d;

    assign tmo_flush = (tmo_q == TW'(TIMEOUT)) && (count_q != '0) && (state_q != ST_FLUSH_PEND);

    always_comb begin
        tmo_d = tmo_q;
        if (accept || count_d == '0 || state_q == ST_FLUSH_PEND) tmo_d = '0;
        else if (tmo_q != TW'(TIMEOUT)) tmo_d = tmo_q + TW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tmo_q <= '0;
        else        tmo_q <= tmo_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
    assign tmo_flush      = 1'b0;
`endif

    mixed_block_c_hdr_fifo #(
        .WIDTH (HDR_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push),
        .push_dat_i (push_hdr),
        .pop_i      (out_valid && out_ready),
        .rd_vld_o   (out_valid),
        .rd_dat_o   (out_hdr),
        .full_o     (fifo_full),
        .level_o    (level)
    );

endmodule
